pwm_multi_ch: RTL and testbench

PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

---
 rtl/pwm_pkg.sv | 34 +++
 rtl/pwm_timebase.sv | 100 ++++++++++
 rtl/pwm_multi_ch.sv | 144 ++++++++++++++
 tb/tb_pwm_multi_ch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared definitions for the multi-channel PWM block.
//                - Register address offsets, relative to NUM_CH, for the
//                  prescaler and mode registers.
//                - Bit positions inside the mode register.
//                - Counting mode enumeration.
//                - Width helper for the configuration data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Addresses 0..NUM_CH-1 select the duty registers.
    // The control registers follow at NUM_CH + offset.
    localparam int ADDR_PRESC = 0;
    localparam int ADDR_MODE  = 1;

    // Bit positions inside the mode register.
    localparam int MODE_CENTER_BIT = 0;
    localparam int MODE_RUN_BIT    = 1;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } pwm_mode_e;

    // The configuration data bus must hold either a duty or a prescaler value.
    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_timebase
//  Description : Shared time base for all PWM channels.
//                A prescaler produces one tick every (i_presc+1) clocks.
//                Each tick advances the counter in one of two patterns:
//                  - Edge mode   : 0..MAX-1, then wraps to 0.
//                  - Center mode : 0..MAX, then MAX-1..1, then back to 0.
//                o_boundary flags the tick on which the counter returns to 0.
//                While i_hold is set, the prescaler and the counter are
//                held at zero.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_hold              - park the counter at 0 (not running)
//                i_center            - 1 selects up/down counting
//                i_presc[PRESC_W]    - prescaler reload value
//                o_cnt[DUTY_W]       - current counter value
//                o_down              - 1 while counting down (center mode)
//                o_boundary          - period boundary, one cycle wide
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase #(
    parameter int DUTY_W  = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_hold,
    input  logic               i_center,
    input  logic [PRESC_W-1:0] i_presc,
    output logic [DUTY_W-1:0]  o_cnt,
    output logic               o_down,
    output logic               o_boundary
);

    localparam logic [DUTY_W-1:0]  c_ONE    = DUTY_W'(1);
    localparam logic [DUTY_W-1:0]  c_MAX    = {DUTY_W{1'b1}};
    localparam logic [DUTY_W-1:0]  c_MAX_M1 = c_MAX - c_ONE;
    localparam logic [PRESC_W-1:0] c_P_ONE  = PRESC_W'(1);

    logic [PRESC_W-1:0] r_presc_cnt;
    logic [DUTY_W-1:0]  r_cnt;
    logic               r_down;
    logic [DUTY_W-1:0]  w_cnt_nxt;
    logic               w_down_nxt;
    logic               w_wrap;
    logic               w_tick;

    assign w_tick = (r_presc_cnt == i_presc);

    // Next counter value, applied only on a tick.
    // A mode change can take effect only at a boundary. At that point the
    // counter is 0 and the direction is up, so both patterns start cleanly.
    always_comb begin
        w_cnt_nxt  = r_cnt + c_ONE;
        w_down_nxt = r_down;
        w_wrap     = 1'b0;
        if (i_center) begin
            if (!r_down) begin
                if (r_cnt == c_MAX) begin
                    w_cnt_nxt  = c_MAX_M1;
                    w_down_nxt = 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) begin
                    w_wrap     = 1'b1;
                    w_down_nxt = 1'b0;
                end
            end
        end else begin
            w_down_nxt = 1'b0;
            // ">=" keeps the counter bounded even if it somehow reaches MAX.
            if (r_cnt >= c_MAX_M1) begin
                w_cnt_nxt = '0;
                w_wrap    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_hold) begin
            r_presc_cnt <= '0;
            r_cnt       <= '0;
            r_down      <= 1'b0;
        end else begin
            // Unsigned compare; the increment wraps modulo 2^PRESC_W.
            r_presc_cnt <= w_tick ? '0 : (r_presc_cnt + c_P_ONE);
            if (w_tick) begin
                r_cnt  <= w_cnt_nxt;
                r_down <= w_down_nxt;
            end
        end
    end

    assign o_cnt      = r_cnt;
    assign o_down     = r_down;
    assign o_boundary = w_tick && w_wrap && !i_hold;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_ch.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_ch
//  Description : NUM_CH-channel PWM generator with shadowed configuration.
//                Writes land in staged registers. The staged registers are
//                copied into the active set at each period boundary, or on
//                every cycle while the block is stopped.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                cfg_we, cfg_addr,    - register write port
//                cfg_wdata              (addr NUM_CH = presc, NUM_CH+1 = mode)
//                ch_en[NUM_CH]        - per-channel output enable
//                pwm_out[NUM_CH]      - registered PWM outputs
//                period_tick          - one-cycle pulse at each period start
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int DUTY_W  = 8,
    parameter int PRESC_W = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_we,
    input  logic [$clog2(NUM_CH+2)-1:0]         cfg_addr,
    input  logic [max_w(DUTY_W, PRESC_W)-1:0]   cfg_wdata,
    input  logic [NUM_CH-1:0]                   ch_en,
    output logic [NUM_CH-1:0]                   pwm_out,
    output logic                                period_tick
);

    localparam int ADDR_W = $clog2(NUM_CH + 2);
    localparam logic [ADDR_W-1:0] c_ADDR_PRESC = ADDR_W'(NUM_CH + ADDR_PRESC);
    localparam logic [ADDR_W-1:0] c_ADDR_MODE  = ADDR_W'(NUM_CH + ADDR_MODE);

    // Staged (CPU-visible) and active (in-use) configuration.
    logic [DUTY_W-1:0]  r_duty_stg [NUM_CH];
    logic [DUTY_W-1:0]  r_duty_act [NUM_CH];
    logic [PRESC_W-1:0] r_presc_stg;
    logic [PRESC_W-1:0] r_presc_act;
    logic [1:0]         r_mode_stg;
    pwm_mode_e          r_mode_act;
    logic               r_run_act;

    logic [NUM_CH-1:0]  r_pwm_out;
    logic               r_period_tick;

    logic [DUTY_W-1:0]  w_cnt;
    logic               w_down;
    logic               w_boundary;
    logic               w_run;
    logic               w_load;
    logic [NUM_CH-1:0]  w_raw;

    // Clearing the staged run bit stops the block at once, without waiting
    // for a boundary. While stopped, the active set tracks the staged set on
    // every cycle, so setting run starts a fresh period with current values.
    assign w_run  = r_run_act && r_mode_stg[MODE_RUN_BIT];
    assign w_load = !w_run || w_boundary;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_stg[i] <= '0;
            end
            r_presc_stg <= '0;
            r_mode_stg  <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_addr == ADDR_W'(i)) begin
                    r_duty_stg[i] <= cfg_wdata[DUTY_W-1:0];
                end
            end
            if (cfg_addr == c_ADDR_PRESC) begin
                r_presc_stg <= cfg_wdata[PRESC_W-1:0];
            end
            if (cfg_addr == c_ADDR_MODE) begin
                r_mode_stg <= cfg_wdata[1:0];
            end
        end
    end

    // The shadow copy reads the staged registers before a write in the
    // same cycle lands. Such a write therefore waits one more period.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_act[i] <= '0;
            end
            r_presc_act <= '0;
            r_mode_act  <= EDGE;
            r_run_act   <= 1'b0;
        end else if (w_load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_act[i] <= r_duty_stg[i];
            end
            r_presc_act <= r_presc_stg;
            r_mode_act  <= r_mode_stg[MODE_CENTER_BIT] ? CENTER : EDGE;
            r_run_act   <= r_mode_stg[MODE_RUN_BIT];
        end
    end

    pwm_timebase #(
        .DUTY_W  (DUTY_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .i_hold     (!w_run),
        .i_center   (r_mode_act == CENTER),
        .i_presc    (r_presc_act),
        .o_cnt      (w_cnt),
        .o_down     (w_down),
        .o_boundary (w_boundary)
    );

    // Edge mode compares cnt < duty.
    // Center mode includes cnt == duty on the rising half only. This gives
    // a pulse of exactly 2*duty ticks, centred on the counter's return to 0.
    // It also keeps duty = MAX high through the apex at cnt = MAX.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_raw[g] = (r_mode_act == CENTER)
                        ? ((r_duty_act[g] != '0) &&
                           (w_down ? (w_cnt <  r_duty_act[g])
                                   : (w_cnt <= r_duty_act[g])))
                        : (w_cnt < r_duty_act[g]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_out     <= '0;
            r_period_tick <= 1'b0;
        end else begin
            r_pwm_out     <= w_raw & ch_en & {NUM_CH{w_run}};
            r_period_tick <= w_boundary;
        end
    end

    assign pwm_out     = r_pwm_out;
    assign period_tick = r_period_tick;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multi_ch
//  Description : Directed self-checking bench for pwm_multi_ch.
//                Configuration: NUM_CH=4, DUTY_W=8, PRESC_W=8 (MAX=255).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_ch;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [3:0] ch_en;
    logic [3:0] pwm_out;
    logic       period_tick;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_multi_ch #(
        .NUM_CH  (4),
        .DUTY_W  (8),
        .PRESC_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .ch_en       (ch_en),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we    = 1'b0;
    endtask

    // Advance until period_tick is seen; n = cycles advanced.
    task automatic wait_tick(input int max_cyc, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max_cyc && !ok) begin
            @(posedge clk); #1;
            n++;
            if (period_tick) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int hi, tk;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (pwm_out !== 4'h0) begin n_fail++; $display("FAIL reset_pwm: got %h expected 0", pwm_out); end
        n_tests++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", period_tick); end
        n_tests++; if (dut.w_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dut.w_cnt); end
        rst = 1'b0;
        hi = 0; tk = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (pwm_out != 4'h0) hi++;
            if (period_tick) tk++;
        end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL idle_pwm: got %0d high cycles expected 0", hi); end
        n_tests++; if (tk != 0) begin n_fail++; $display("FAIL idle_tick: got %0d ticks expected 0", tk); end
    endtask

    task automatic test_edge();
        int n, extra;
        bit ok;
        int hi [4];
        int exp_hi [4];
        bit [254:0] s0;
        exp_hi = '{64, 0, 255, 128};
        hi     = '{0, 0, 0, 0};
        extra  = 0;
        cfg_write(3'd0, 8'd64);
        cfg_write(3'd1, 8'd0);
        cfg_write(3'd2, 8'd255);
        cfg_write(3'd3, 8'd128);
        cfg_write(3'd4, 8'd0);
        cfg_write(3'd5, 8'd2);
        // The run bit activates one edge after the write.
        // The counter then needs 255 ticks to wrap.
        wait_tick(400, n, ok);
        n_tests++; if (!ok || n != 256) begin n_fail++; $display("FAIL edge_first_tick: got %0d cycles (seen=%0d) expected 256", n, ok); end
        for (int i = 0; i < 255; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            for (int c = 0; c < 4; c++) if (pwm_out[c]) hi[c]++;
            s0[i] = pwm_out[0];
            if (i > 0 && period_tick) extra++;
        end
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (hi[c] != exp_hi[c]) begin n_fail++; $display("FAIL edge_high_ch%0d: got %0d expected %0d", c, hi[c], exp_hi[c]); end
        end
        n_tests++; if (s0[0] !== 1'b0 || s0[1] !== 1'b1) begin n_fail++; $display("FAIL edge_rise: got %b%b expected 01", s0[0], s0[1]); end
        n_tests++; if (s0[64] !== 1'b1 || s0[65] !== 1'b0) begin n_fail++; $display("FAIL edge_fall: got %b%b expected 10", s0[64], s0[65]); end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL edge_tick_extra: got %0d expected 0", extra); end
        @(posedge clk); #1;
        n_tests++; if (period_tick !== 1'b1) begin n_fail++; $display("FAIL edge_period: got %b expected 1", period_tick); end
    endtask

    task automatic test_duty_extremes();
        int hi1, lo2, tk;
        hi1 = 0; lo2 = 0; tk = 0;
        repeat (765) begin
            @(posedge clk); #1;
            if (pwm_out[1]) hi1++;
            if (!pwm_out[2]) lo2++;
            if (period_tick) tk++;
        end
        n_tests++; if (hi1 != 0) begin n_fail++; $display("FAIL duty0_const: got %0d high expected 0", hi1); end
        n_tests++; if (lo2 != 0) begin n_fail++; $display("FAIL dutymax_const: got %0d low expected 0", lo2); end
        n_tests++; if (tk != 3) begin n_fail++; $display("FAIL extremes_ticks: got %0d expected 3", tk); end
    endtask

    task automatic test_shadow();
        int n, on_t, off_t;
        bit ok;
        int hi [4];
        int exp_hi [4];
        // Write 200 mid-period. Write 30 on the load edge itself; it should
        // then wait one extra period.
        exp_hi = '{64, 200, 200, 30};
        hi     = '{0, 0, 0, 0};
        on_t = 0; off_t = 0;
        wait_tick(300, n, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL shadow_sync: got no tick expected tick"); end
        for (int i = 0; i < 1020; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (pwm_out[0]) hi[i / 255]++;
            if (i > 0 && period_tick) begin
                if (i % 255 == 0) on_t++; else off_t++;
            end
            cfg_we    = (i == 100) || (i == 509);
            cfg_addr  = 3'd0;
            cfg_wdata = (i == 100) ? 8'd200 : 8'd30;
        end
        cfg_we = 1'b0;
        for (int w = 0; w < 4; w++) begin
            n_tests++;
            if (hi[w] != exp_hi[w]) begin n_fail++; $display("FAIL shadow_period%0d: got %0d high expected %0d", w, hi[w], exp_hi[w]); end
        end
        n_tests++; if (on_t != 3 || off_t != 0) begin n_fail++; $display("FAIL shadow_ticks: got %0d/%0d expected 3/0", on_t, off_t); end
    endtask

    task automatic test_center();
        int n, hi, extra;
        bit ok;
        bit [1019:0] s;
        hi = 0; extra = 0;
        cfg_write(3'd4, 8'd1);
        cfg_write(3'd0, 8'd100);
        cfg_write(3'd5, 8'd3);
        wait_tick(300, n, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL center_load: got no tick expected tick"); end
        wait_tick(1100, n, ok);
        n_tests++; if (!ok || n != 1020) begin n_fail++; $display("FAIL center_period: got %0d cycles expected 1020", n); end
        for (int i = 0; i < 1020; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            s[i] = pwm_out[0];
            if (pwm_out[0]) hi++;
            if (i > 0 && period_tick) extra++;
        end
        n_tests++; if (hi != 400) begin n_fail++; $display("FAIL center_high: got %0d clk expected 400", hi); end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL center_tick_extra: got %0d expected 0", extra); end
        // The pulse straddles the boundary. The apex (cnt near MAX) stays low.
        n_tests++; if (s[0] !== 1'b1 || s[1] !== 1'b1) begin n_fail++; $display("FAIL center_mid: got %b%b expected 11", s[0], s[1]); end
        n_tests++; if (s[202] !== 1'b1 || s[203] !== 1'b0 || s[510] !== 1'b0) begin n_fail++; $display("FAIL center_up_edge: got %b%b%b expected 100", s[202], s[203], s[510]); end
        n_tests++; if (s[822] !== 1'b0 || s[823] !== 1'b1) begin n_fail++; $display("FAIL center_down_edge: got %b%b expected 01", s[822], s[823]); end
        @(posedge clk); #1;
        n_tests++; if (period_tick !== 1'b1) begin n_fail++; $display("FAIL center_next_tick: got %b expected 1", period_tick); end
    endtask

    task automatic test_gating();
        int n, bad;
        bit ok;
        bad = 0;
        cfg_write(3'd5, 8'd0);
        @(posedge clk); #1;
        n_tests++; if (pwm_out !== 4'h0 || period_tick !== 1'b0) begin n_fail++; $display("FAIL stop_outputs: got %h/%b expected 0/0", pwm_out, period_tick); end
        n_tests++; if (dut.w_cnt !== 8'd0) begin n_fail++; $display("FAIL stop_cnt: got %0d expected 0", dut.w_cnt); end
        repeat (20) begin
            @(posedge clk); #1;
            if (pwm_out != 4'h0 || period_tick || dut.w_cnt != 8'd0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stop_hold: got %0d active cycles expected 0", bad); end
        cfg_write(3'd4, 8'd0);
        cfg_write(3'd5, 8'd2);
        wait_tick(400, n, ok);
        n_tests++; if (!ok || n != 256) begin n_fail++; $display("FAIL rerun_first_tick: got %0d cycles expected 256", n); end
        @(posedge clk); #1;
        n_tests++; if (pwm_out[3] !== 1'b1) begin n_fail++; $display("FAIL en_before: got %b expected 1", pwm_out[3]); end
        ch_en = 4'b0111;
        @(posedge clk); #1;
        n_tests++; if (pwm_out[3] !== 1'b0 || pwm_out[0] !== 1'b1) begin n_fail++; $display("FAIL en_clear: got ch3=%b ch0=%b expected 0 1", pwm_out[3], pwm_out[0]); end
        ch_en = 4'hF;
        @(posedge clk); #1;
        n_tests++; if (pwm_out[3] !== 1'b1) begin n_fail++; $display("FAIL en_restore: got %b expected 1", pwm_out[3]); end
    endtask

    task automatic test_reset_mid();
        int n, hi, tk;
        n = 0;
        while (n < 300 && dut.w_cnt != 8'd100) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++; if (dut.w_cnt !== 8'd100) begin n_fail++; $display("FAIL rstmid_reach: got cnt %0d expected 100", dut.w_cnt); end
        n_tests++; if (pwm_out !== 4'b1101) begin n_fail++; $display("FAIL rstmid_before: got %b expected 1101", pwm_out); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (pwm_out !== 4'h0 || period_tick !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got %h/%b expected 0/0", pwm_out, period_tick); end
        n_tests++; if (dut.w_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", dut.w_cnt); end
        n_tests++;
        if (dut.r_duty_act[0] !== 8'd0 || dut.r_duty_stg[3] !== 8'd0 || dut.r_presc_stg !== 8'd0 ||
            dut.r_presc_act !== 8'd0 || dut.r_mode_stg !== 2'd0 || dut.r_run_act !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_regs: got duty_act0=%0d duty_stg3=%0d presc=%0d/%0d mode=%0d run=%b expected all 0",
                     dut.r_duty_act[0], dut.r_duty_stg[3], dut.r_presc_stg, dut.r_presc_act, dut.r_mode_stg, dut.r_run_act);
        end
        rst = 1'b0;
        hi = 0; tk = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (pwm_out != 4'h0) hi++;
            if (period_tick) tk++;
        end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL rstmid_idle_pwm: got %0d high expected 0", hi); end
        n_tests++; if (tk != 0) begin n_fail++; $display("FAIL rstmid_idle_tick: got %0d expected 0", tk); end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 3'd0;
        cfg_wdata = 8'd0;
        ch_en     = 4'hF;
        test_reset();
        test_edge();
        test_duty_extremes();
        test_shadow();
        test_center();
        test_gating();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
